// File: rtl/qsys_key_pio_in.sv
// Avalon-MM input PIO for push-buttons/switches: 2-FF synchronizer, per-bit
// debouncer, edge capture with write-one-to-clear, maskable level irq.
module qsys_key_pio_in #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  typedef enum int unsigned {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_sel_e;

  addr_e addr;
  assign addr = addr_e'(address);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         deb_q, deb_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         mask_q, mask_d;
  logic [WIDTH-1:0]         edge_q, edge_d;

  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [WIDTH-1:0] clear;
  logic             wr_en;

  // Only the low WIDTH bits of writedata are meaningful.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  // ---------------------------------------------------------------------------
  // Debounce: a bit is accepted only after sync2 has disagreed with the
  // debounced level for DEBOUNCE_CYCLES consecutive edges.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detect on the debounced level, coincident with the deb update
  // ---------------------------------------------------------------------------
  assign rise = ~deb_q & deb_d;
  assign fall = deb_q & ~deb_d;

  always_comb begin
    case (edge_sel_e'(EDGE_TYPE))
      EDGE_RISE: edge_det = rise;
      EDGE_FALL: edge_det = fall;
      default:   edge_det = rise | fall;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CPU writes: mask load and write-one-to-clear of edge capture
  // ---------------------------------------------------------------------------
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_d = mask_q;
    clear  = '0;
    if (wr_en) begin
      case (addr)
        ADDR_MASK: mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE: clear  = writedata[WIDTH-1:0];
        default:   ;
      endcase
    end
  end

  // A fresh edge in the same cycle as a clear keeps the bit set.
  assign edge_d = edge_det | (edge_q & ~clear);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      deb_q   <= RESET_VALUE;
      // NOTE: the counter array is small flop state, not RAM, so it is reset
      // explicitly; an unreset counter could accept a glitch right after reset.
      cnt_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
    end else begin
      // NOTE: non-blocking so sync2 takes the old sync1, forming two real stages.
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (zero-wait, chipselect not required) and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (addr)
      ADDR_DATA: readdata[WIDTH-1:0] = deb_q;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_qsys_key_pio_in.sv
// Directed bench for qsys_key_pio_in: one falling-edge instance and one
// any-edge instance share every input so both capture modes are exercised.
module tb_qsys_key_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata, rdata_any;
  logic        irq, irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qsys_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  qsys_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(4'hF)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata_any), .irq(irq_any)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rd(2'd0);
    checks++; if (readdata !== 32'h0000000F) begin errors++; $display("FAIL reset_addr0: got %h expected 0000000f", readdata); end
    rd(2'd2);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_addr2: got %h expected 00000000", readdata); end
    rd(2'd3);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_addr3: got %h expected 00000000", readdata); end
    #2 reset_n = 1'b1;
    tick(6);
    rd(2'd3);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL reset_no_edge: got %h expected 00000000", rdata_any); end
  endtask

  task automatic test_debounce_latency;
    in_port[0] = 1'b0;
    tick(5);
    rd(2'd0);
    checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL deb_edge5: got %h expected 0000000f", readdata); end
    tick(1);
    rd(2'd0);
    checks++; if (readdata !== 32'hE) begin errors++; $display("FAIL deb_edge6: got %h expected 0000000e", readdata); end
    rd(2'd3);
    checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL deb_capture: got %h expected 00000001", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deb_irq_masked: got %b expected 0", irq); end
    in_port[0] = 1'b1;
    tick(8);
    rd(2'd0);
    checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL deb_release: got %h expected 0000000f", readdata); end
    rd(2'd3);
    checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL deb_no_rise: got %h expected 00000001", readdata); end
    wr(2'd3, 32'hF);
    rd(2'd3);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL deb_clear: got %h expected 00000000", readdata); end
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL deb_clear_any: got %h expected 00000000", rdata_any); end
  endtask

  task automatic test_glitch_reject;
    in_port[1] = 1'b0;
    tick(3);
    in_port[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rd(2'd0);
      checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL glitch_cyc%0d: got %h expected 0000000f", c, readdata); end
      tick(1);
    end
    rd(2'd3);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h expected 00000000", readdata); end
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL glitch_edge_any: got %h expected 00000000", rdata_any); end
  endtask

  task automatic test_irq_path;
    wr(2'd2, 32'h2);
    rd(2'd2);
    checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL irq_mask_rd: got %h expected 00000002", readdata); end
    in_port[1] = 1'b0;
    tick(5);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    rd(2'd3);
    checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL irq_capture: got %h expected 00000002", readdata); end
    tick(4);
    in_port[1] = 1'b1;
    tick(8);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_held: got %b expected 1", irq); end
    wr(2'd3, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL irq_clear_any: got %b expected 0", irq_any); end
    rd(2'd3);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL irq_addr3: got %h expected 00000000", readdata); end
  endtask

  task automatic test_clear_collision;
    in_port[2] = 1'b0;
    tick(5);
    wr(2'd3, 32'h4);
    rd(2'd3);
    checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL collide_keep: got %h expected 00000004", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collide_irq_masked: got %b expected 0", irq); end
    in_port[2] = 1'b1;
    tick(8);
    wr(2'd3, 32'hF);
    rd(2'd3);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL collide_clear: got %h expected 00000000", readdata); end
  endtask

  task automatic test_any_edge;
    in_port[3] = 1'b0;
    tick(5);
    rd(2'd3);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL any_press_early: got %h expected 00000000", rdata_any); end
    tick(1);
    rd(2'd3);
    checks++; if (rdata_any !== 32'h8) begin errors++; $display("FAIL any_press: got %h expected 00000008", rdata_any); end
    checks++; if (readdata !== 32'h8) begin errors++; $display("FAIL fall_press: got %h expected 00000008", readdata); end
    wr(2'd3, 32'h8);
    rd(2'd3);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL any_cleared: got %h expected 00000000", rdata_any); end
    in_port[3] = 1'b1;
    tick(6);
    rd(2'd3);
    checks++; if (rdata_any !== 32'h8) begin errors++; $display("FAIL any_release: got %h expected 00000008", rdata_any); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL fall_no_release: got %h expected 00000000", readdata); end
    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd1, 32'hFFFFFFFF);
    rd(2'd0);
    checks++; if (rdata_any !== 32'hF) begin errors++; $display("FAIL ro_addr0: got %h expected 0000000f", rdata_any); end
    rd(2'd1);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL ro_addr1: got %h expected 00000000", rdata_any); end
    rd(2'd2);
    checks++; if (rdata_any !== 32'h2) begin errors++; $display("FAIL ro_addr2: got %h expected 00000002", rdata_any); end
    rd(2'd3);
    checks++; if (rdata_any !== 32'h8) begin errors++; $display("FAIL ro_addr3: got %h expected 00000008", rdata_any); end
  endtask

  task automatic test_reset_mid;
    wr(2'd2, 32'h8);
    checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL mid_irq_before: got %b expected 1", irq_any); end
    in_port[0] = 1'b0;
    tick(3);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL mid_irq_async: got %b expected 0", irq_any); end
    rd(2'd0);
    checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL mid_addr0: got %h expected 0000000f", readdata); end
    rd(2'd2);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL mid_addr2: got %h expected 00000000", rdata_any); end
    rd(2'd3);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL mid_addr3: got %h expected 00000000", rdata_any); end
    in_port = 4'hF;
    tick(2);
    #2 reset_n = 1'b1;
    tick(8);
    rd(2'd0);
    checks++; if (rdata_any !== 32'hF) begin errors++; $display("FAIL post_addr0: got %h expected 0000000f", rdata_any); end
    rd(2'd3);
    checks++; if (rdata_any !== 32'h0) begin errors++; $display("FAIL post_addr3: got %h expected 00000000", rdata_any); end
  endtask

  initial begin
    test_reset;
    test_debounce_latency;
    test_glitch_reject;
    test_irq_path;
    test_clear_collision;
    test_any_edge;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
